fwd_hazard_ctrl: RTL

- Generates the 2-bit select codes that drive the EX-stage 3:1 operand-forwarding muxes, plus pipeline stall/flush controls.
- Keeps its own shadow pipeline of destination-register info for the EX, MEM and WB stages.
- Sits beside the 5-stage datapath and consumes decode-stage fields and the EX-stage branch-taken flag.

---
 rtl/fwd_hazard_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: operand-forwarding and hazard control for a 5-stage pipeline.
//
// Holds a shadow copy of the destination-register info for the EX, MEM and WB stages.
// From that copy it drives:
//   - the EX-stage 3:1 forwarding-mux selects, and
//   - the fetch/decode stall and flush controls.
//
// Ports:
//   clk, rst_n                 core clock (rising edge), async active-low reset
//   rs1_d, rs2_d, rd_d         decode-stage register indices
//   reg_write_d, is_load_d     decode-stage write-enable and load flags
//   pc_src_e                   branch/jump taken, resolved in EX
//   forward_a_e, forward_b_e   mux selects: 00 regfile, 01 WB result, 10 MEM ALU result
//   stall_f, stall_d           hold PC / hold IF/ID (load-use hazard)
//   flush_d, flush_e           clear IF/ID / insert bubble into ID/EX
//   stall_cnt, flush_cnt       performance counters
//
// Optional feature (macro FWD_HAZARD_STALL_CNT_EN):
//   - Defined: builds saturating stall and flush cycle counters.
//   - Undefined: no counter flops are built, and both count outputs read 0.
module fwd_hazard_ctrl #(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] rs1_d,
   input  logic [REG_ADDR_W-1:0] rs2_d,
   input  logic [REG_ADDR_W-1:0] rd_d,
   input  logic                  reg_write_d,
   input  logic                  is_load_d,
   input  logic                  pc_src_e,
   output logic [1:0]            forward_a_e,
   output logic [1:0]            forward_b_e,
   output logic                  stall_f,
   output logic                  stall_d,
   output logic                  flush_d,
   output logic                  flush_e,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   logic [REG_ADDR_W-1:0] rs1_e_q, rs2_e_q, rd_e_q, rd_m_q, rd_w_q;
   logic                  rw_e_q, ld_e_q, rw_m_q, rw_w_q;
   logic                  lw_stall;

   // MEM beats WB when both hold the register.
   // x0 is hard-wired, so it never forwards.
   function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs,
                                          input logic [REG_ADDR_W-1:0] rd_m,
                                          input logic                  rw_m,
                                          input logic [REG_ADDR_W-1:0] rd_w,
                                          input logic                  rw_w);
      logic [1:0] sel;
      sel = 2'b00;
      if (rw_m && (rd_m != '0) && (rd_m == rs)) begin
         sel = 2'b10;
      end else if (rw_w && (rd_w != '0) && (rd_w == rs)) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   always_comb begin
      forward_a_e = fwd_sel(rs1_e_q, rd_m_q, rw_m_q, rd_w_q, rw_w_q);
      forward_b_e = fwd_sel(rs2_e_q, rd_m_q, rw_m_q, rd_w_q, rw_w_q);
   end

   // A load in EX whose result the decode instruction needs must wait one cycle.
   // The bubble inserted behind it clears ld_e, so the stall self-terminates.
   always_comb begin
      lw_stall = ld_e_q & rw_e_q & (rd_e_q != '0) &
                 ((rd_e_q == rs1_d) | (rd_e_q == rs2_d));
      stall_f  = lw_stall;
      stall_d  = lw_stall;
      flush_d  = pc_src_e;
      flush_e  = lw_stall | pc_src_e;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs1_e_q <= '0;
         rs2_e_q <= '0;
         rd_e_q  <= '0;
         rw_e_q  <= 1'b0;
         ld_e_q  <= 1'b0;
         rd_m_q  <= '0;
         rw_m_q  <= 1'b0;
         rd_w_q  <= '0;
         rw_w_q  <= 1'b0;
      end else begin
         if (flush_e) begin
            rs1_e_q <= '0;
            rs2_e_q <= '0;
            rd_e_q  <= '0;
            rw_e_q  <= 1'b0;
            ld_e_q  <= 1'b0;
         end else begin
            rs1_e_q <= rs1_d;
            rs2_e_q <= rs2_d;
            rd_e_q  <= rd_d;
            rw_e_q  <= reg_write_d;
            ld_e_q  <= is_load_d;
         end
         rd_m_q <= rd_e_q;
         rw_m_q <= rw_e_q;
         rd_w_q <= rd_m_q;
         rw_w_q <= rw_m_q;
      end
   end

`ifdef FWD_HAZARD_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_d && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         end
         if (flush_d && (flush_cnt_q != '1)) begin
            flush_cnt_q <= flush_cnt_q + CNT_W'(1);
         end
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule
